// File: rtl/sm_hex_scanner_pkg.sv
// sm_hex_pkg: constants and helpers shared by the hex scanner and its decoder.
//   SEG_OFF      - all segments dark (active-low)
//   IDX_W        - width of the digit index
//   anodes_off() - every anode deasserted (active-low, MAX_DIGITS wide)
//   anode_sel()  - one-hot-low anode pattern for a digit index
package sm_hex_pkg;
  localparam int          IDX_W      = 3;
  localparam int          MAX_DIGITS = 8;
  localparam logic [6:0]  SEG_OFF    = 7'h7F;

  typedef logic [6:0] seg_t;

  function automatic logic [MAX_DIGITS-1:0] anodes_off();
    return '1;
  endfunction

  function automatic logic [MAX_DIGITS-1:0] anode_sel(input logic [IDX_W-1:0] idx);
    return ~(MAX_DIGITS'(1) << idx);
  endfunction
endpackage

// File: rtl/sm_hex_scanner_if.sv
// sm_hex_if: display-side bus of the hex scanner.
//   en       - scan enable (low freezes scan and blanks digits)
//   value    - 32-bit number to show, nibble i on digit i
//   anodes   - digit selects, active-low
//   segments - {g,f,e,d,c,b,a}, active-low
//   frame    - one-clock pulse at the start of each frame
// master drives en/value (CPU debug side); slave is the scanner.
interface sm_hex_if #(
  parameter int DIGITS = 8
);
  logic              en;
  logic [31:0]       value;
  logic [DIGITS-1:0] anodes;
  logic [6:0]        segments;
  logic              frame;

  modport master (output en, value, input anodes, segments, frame);
  modport slave  (input en, value, output anodes, segments, frame);
endinterface

// File: rtl/sm_hex_scanner_display.sv
// sm_hex_display: combinational hex nibble to seven-segment decoder.
//   nibble_i - 4-bit hex digit
//   seg_o    - segments {g,f,e,d,c,b,a}, active-low (common anode)
module sm_hex_display
  import sm_hex_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg_t       seg_o
);
  always_comb begin
    seg_o = SEG_OFF;
    unique case (nibble_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
    endcase
  end
endmodule

// File: rtl/sm_hex_scanner.sv
// sm_hex_scanner: time-multiplexed driver for up to eight common-anode
// seven-segment digits. One shared decoder; value is latched into a shadow
// register once per frame so a frame never mixes two values.
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - sm_hex_if slave: en, value in; anodes, segments, frame out
// Parameters: DIGITS (1..8) digit positions, DIV_W prescaler width
// (each digit slot lasts 2^DIV_W clocks).
// Optional macro SM_HEX_BLANK_EN: leading-zero blanking of digits above 0.
module sm_hex_scanner
  import sm_hex_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int DIV_W  = 16
)(
  input  logic clk,
  input  logic rst,
  sm_hex_if.slave bus
);
  logic [DIV_W-1:0]      div_q,      div_d;
  logic [IDX_W-1:0]      idx_q,      idx_d;
  logic [31:0]           shadow_q,   shadow_d;
  logic [DIGITS-1:0]     anodes_q,   anodes_d;
  seg_t                  seg_q,      seg_d;
  // [0]: wrap happened last edge, [1]: frame (digit 0 now on anodes)
  logic [1:0]            vld_pipe_q, vld_pipe_d;

  logic                  tick, wrap, blank;
  logic [3:0]            nibble;
  seg_t                  dec_seg;
  logic [MAX_DIGITS-1:0] sel_full, off_full;

  assign tick     = (&div_q) & bus.en;
  assign wrap     = tick && (idx_q == IDX_W'(DIGITS - 1));
  assign nibble   = shadow_q[{idx_q, 2'b00} +: 4];
  assign sel_full = anode_sel(idx_q);
  assign off_full = anodes_off();

  sm_hex_display u_dec (
    .nibble_i (nibble),
    .seg_o    (dec_seg)
  );

`ifdef SM_HEX_BLANK_EN
  // upper_zero[i]: shadow nibbles i..DIGITS-1 are all zero
  logic [MAX_DIGITS-1:0] upper_zero;
  for (genvar g = 0; g < MAX_DIGITS; g++) begin : g_lz
    if (g < DIGITS) begin : g_on
      assign upper_zero[g] = ~|shadow_q[4*DIGITS-1 : 4*g];
    end else begin : g_off
      assign upper_zero[g] = 1'b0;
    end
  end
  // digit 0 is never blanked so a zero value still reads "0"
  assign blank = (idx_q != '0) && upper_zero[idx_q];
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    div_d      = div_q;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    anodes_d   = anodes_q;
    seg_d      = seg_q;
    vld_pipe_d = {vld_pipe_q[0], 1'b0};
    if (bus.en) begin
      div_d = div_q + 1'b1;
      if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;
      if (wrap) begin
        shadow_d      = bus.value;
        vld_pipe_d[0] = 1'b1;
      end
      // outputs follow the current idx one clock later, anodes and segments together
      anodes_d = sel_full[DIGITS-1:0];
      seg_d    = blank ? SEG_OFF : dec_seg;
    end else begin
      // segments hold; digits go dark
      anodes_d = off_full[DIGITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= '0;
      idx_q      <= '0;
      shadow_q   <= '0;
      anodes_q   <= off_full[DIGITS-1:0];
      seg_q      <= SEG_OFF;
      vld_pipe_q <= '0;
    end else begin
      div_q      <= div_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      anodes_q   <= anodes_d;
      seg_q      <= seg_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  assign bus.anodes   = anodes_q;
  assign bus.segments = seg_q;
  assign bus.frame    = vld_pipe_q[1];
endmodule

// File: tb/tb_sm_hex_scanner.sv
module tb_sm_hex_scanner;
  localparam int DW   = 2;
  localparam int SLOT = 1 << DW;    // clocks per digit
  localparam int FR8  = 8 * SLOT;   // clocks per frame, 8 digits

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sm_hex_if #(.DIGITS(8)) bus8();
  sm_hex_if #(.DIGITS(1)) bus1();

  sm_hex_scanner #(.DIGITS(8), .DIV_W(DW)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  sm_hex_scanner #(.DIGITS(1), .DIV_W(DW)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  // expected pattern for digit k of an 8-digit display holding sh
  function automatic logic [6:0] digit_seg(input logic [31:0] sh, input int k);
    logic [31:0] upper;
    upper = sh >> (4 * k);
`ifdef SM_HEX_BLANK_EN
    if (k > 0 && upper == 32'd0) return 7'h7F;
`endif
    return hex7(upper[3:0]);
  endfunction

  // Reference model: one running count of enabled clocks since reset;
  // digit = (count / SLOT) % DIGITS, a new frame whenever the count hits a
  // multiple of the frame length.
  int         m8_cnt, m1_cnt;
  logic [31:0] m8_sh, m1_sh;
  logic [7:0] m8_an;
  logic       m1_an;
  logic [6:0] m8_seg, m1_seg;
  logic       m8_wrap, m8_frame, m1_wrap, m1_frame;

  always @(posedge clk) begin
    if (rst) begin
      m8_cnt <= 0; m8_sh <= '0; m8_an <= 8'hFF; m8_seg <= 7'h7F; m8_wrap <= 1'b0; m8_frame <= 1'b0;
    end else begin
      m8_frame <= m8_wrap;
      if (bus8.en) begin
        m8_an   <= ~(8'd1 << ((m8_cnt / SLOT) % 8));
        m8_seg  <= digit_seg(m8_sh, (m8_cnt / SLOT) % 8);
        m8_cnt  <= m8_cnt + 1;
        m8_wrap <= ((m8_cnt + 1) % FR8 == 0);
        if ((m8_cnt + 1) % FR8 == 0) m8_sh <= bus8.value;
      end else begin
        m8_an   <= 8'hFF;
        m8_wrap <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m1_cnt <= 0; m1_sh <= '0; m1_an <= 1'b1; m1_seg <= 7'h7F; m1_wrap <= 1'b0; m1_frame <= 1'b0;
    end else begin
      m1_frame <= m1_wrap;
      if (bus1.en) begin
        m1_an   <= 1'b0;
        m1_seg  <= hex7(m1_sh[3:0]);
        m1_cnt  <= m1_cnt + 1;
        m1_wrap <= ((m1_cnt + 1) % SLOT == 0);
        if ((m1_cnt + 1) % SLOT == 0) m1_sh <= bus1.value;
      end else begin
        m1_an   <= 1'b1;
        m1_wrap <= 1'b0;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; bus8.en = 1'b1; bus1.en = 1'b1;
    bus8.value = $urandom; bus1.value = 32'hF;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if (bus8.anodes !== 8'hFF || bus8.segments !== 7'h7F || bus8.frame !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: an=%h seg=%h fr=%b, want FF 7F 0", bus8.anodes, bus8.segments, bus8.frame);
      end
    end
    rst = 1'b0;
    bus8.value = 32'h76543210;
    @(negedge clk);
    n_tests++;
    if (bus8.anodes !== 8'hFE || bus8.segments !== 7'h40 || bus8.frame !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: an=%h seg=%h fr=%b, want FE 40 0", bus8.anodes, bus8.segments, bus8.frame);
    end
  endtask

  task automatic test_scan_order();
    int frames = 0;
    int last   = -1;
    for (int c = 0; c < 3 * FR8; c++) begin
      @(negedge clk);
      n_tests++;
      if ({bus8.anodes, bus8.segments, bus8.frame} !== {m8_an, m8_seg, m8_frame}) begin
        n_fail++;
        $display("FAIL scan_model: got %h %h %b want %h %h %b",
                 bus8.anodes, bus8.segments, bus8.frame, m8_an, m8_seg, m8_frame);
      end
      if (bus8.frame === 1'b1) begin
        if (last >= 0) begin
          n_tests++;
          if (c - last != FR8) begin
            n_fail++;
            $display("FAIL scan_frame_period: got %0d want %0d", c - last, FR8);
          end
        end
        last = c;
        frames++;
      end
      if (frames >= 1) begin
        if (bus8.anodes === 8'hFE) begin
          n_tests++;
          if (bus8.segments !== 7'h40) begin n_fail++; $display("FAIL scan_d0: got %h want 40", bus8.segments); end
        end
        if (bus8.anodes === 8'hFD) begin
          n_tests++;
          if (bus8.segments !== 7'h79) begin n_fail++; $display("FAIL scan_d1: got %h want 79", bus8.segments); end
        end
        if (bus8.anodes === 8'h7F) begin
          n_tests++;
          if (bus8.segments !== 7'h78) begin n_fail++; $display("FAIL scan_d7: got %h want 78", bus8.segments); end
        end
      end
    end
    n_tests++;
    if (frames < 2) begin n_fail++; $display("FAIL scan_frames: got %0d frame pulses want >=2", frames); end
  endtask

  task automatic test_no_tearing();
    int t;
    int phase = 0;   // 0: before change, 1: changed mid-frame, 2: next frame
    bus8.value = 32'h11111111;
    for (int f = 0; f < 2; f++) begin
      t = 0;
      @(negedge clk);
      while (bus8.frame !== 1'b1 && t < 3 * FR8) begin @(negedge clk); t++; end
      if (t >= 3 * FR8) begin n_tests++; n_fail++; $display("FAIL tear_wait: got no frame pulse want one"); end
    end
    t = 0;
    while (bus8.anodes !== 8'hF7 && t < 2 * FR8) begin @(negedge clk); t++; end
    if (t >= 2 * FR8) begin n_tests++; n_fail++; $display("FAIL tear_wait_d3: got no digit 3 want it"); end
    bus8.value = 32'h22222222;
    phase = 1;
    for (int c = 0; c < 2 * FR8; c++) begin
      @(negedge clk);
      n_tests++;
      if ({bus8.anodes, bus8.segments, bus8.frame} !== {m8_an, m8_seg, m8_frame}) begin
        n_fail++;
        $display("FAIL tear_model: got %h %h %b want %h %h %b",
                 bus8.anodes, bus8.segments, bus8.frame, m8_an, m8_seg, m8_frame);
      end
      if (bus8.frame === 1'b1) phase = 2;
      if (phase == 1 && bus8.anodes inside {8'hEF, 8'hDF, 8'hBF, 8'h7F}) begin
        n_tests++;
        if (bus8.segments !== 7'h79) begin n_fail++; $display("FAIL tear_old: got %h want 79", bus8.segments); end
      end
      if (phase == 2) begin
        n_tests++;
        if (bus8.segments !== 7'h24) begin n_fail++; $display("FAIL tear_new: got %h want 24", bus8.segments); end
      end
    end
  endtask

  task automatic test_enable();
    int t = 0;
    logic [6:0] held;
    logic [7:0] first;
    while (bus8.anodes !== 8'hDF && t < 2 * FR8) begin @(negedge clk); t++; end
    if (t >= 2 * FR8) begin n_tests++; n_fail++; $display("FAIL en_wait: got no digit 5 want it"); end
    held = bus8.segments;
    bus8.en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_tests++;
      if (bus8.anodes !== 8'hFF || bus8.segments !== held || bus8.frame !== m8_frame) begin
        n_fail++;
        $display("FAIL en_off: got an=%h seg=%h want FF %h", bus8.anodes, bus8.segments, held);
      end
    end
    bus8.en = 1'b1;
    first = 8'hFF;
    for (int c = 0; c < 2 * FR8; c++) begin
      @(negedge clk);
      if (first === 8'hFF) first = bus8.anodes;
      n_tests++;
      if ({bus8.anodes, bus8.segments, bus8.frame} !== {m8_an, m8_seg, m8_frame}) begin
        n_fail++;
        $display("FAIL en_resume: got %h %h %b want %h %h %b",
                 bus8.anodes, bus8.segments, bus8.frame, m8_an, m8_seg, m8_frame);
      end
    end
    n_tests++;
    if (first !== 8'hDF) begin n_fail++; $display("FAIL en_first_digit: got %h want DF", first); end
  endtask

  task automatic test_blanking();
    logic [31:0] vals [2] = '{32'h000000A5, 32'h00000000};
    int t;
    logic [6:0] want;
    for (int v = 0; v < 2; v++) begin
      bus8.value = vals[v];
      for (int f = 0; f < 2; f++) begin
        t = 0;
        @(negedge clk);
        while (bus8.frame !== 1'b1 && t < 3 * FR8) begin @(negedge clk); t++; end
        if (t >= 3 * FR8) begin n_tests++; n_fail++; $display("FAIL blank_wait: got no frame want one"); end
      end
      for (int c = 0; c < FR8; c++) begin
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          if (bus8.anodes === ~(8'd1 << k)) begin
            if (k == 0)      want = (v == 0) ? 7'h12 : 7'h40;
            else if (k == 1 && v == 0) want = 7'h08;
            else begin
`ifdef SM_HEX_BLANK_EN
              want = 7'h7F;
`else
              want = 7'h40;
`endif
            end
            n_tests++;
            if (bus8.segments !== want) begin
              n_fail++;
              $display("FAIL blank_d%0d: value=%h got %h want %h", k, vals[v], bus8.segments, want);
            end
          end
        end
      end
    end
  endtask

  task automatic test_digits1();
    int last = -1;
    bus1.value = 32'h0000000F;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      n_tests++;
      if ({bus1.anodes, bus1.segments, bus1.frame} !== {m1_an, m1_seg, m1_frame}) begin
        n_fail++;
        $display("FAIL d1_model: got %b %h %b want %b %h %b",
                 bus1.anodes, bus1.segments, bus1.frame, m1_an, m1_seg, m1_frame);
      end
      if (c >= 8) begin
        n_tests++;
        if (bus1.anodes !== 1'b0 || bus1.segments !== 7'h0E) begin
          n_fail++;
          $display("FAIL d1_const: got %b %h want 0 0E", bus1.anodes, bus1.segments);
        end
      end
      if (bus1.frame === 1'b1) begin
        if (last >= 0) begin
          n_tests++;
          if (c - last != SLOT) begin n_fail++; $display("FAIL d1_frame_period: got %0d want %0d", c - last, SLOT); end
        end
        last = c;
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      n_tests++;
      if ({bus8.anodes, bus8.segments, bus8.frame} !== {m8_an, m8_seg, m8_frame}) begin
        n_fail++;
        $display("FAIL rand8: cyc %0d got %h %h %b want %h %h %b", c,
                 bus8.anodes, bus8.segments, bus8.frame, m8_an, m8_seg, m8_frame);
      end
      n_tests++;
      if ({bus1.anodes, bus1.segments, bus1.frame} !== {m1_an, m1_seg, m1_frame}) begin
        n_fail++;
        $display("FAIL rand1: cyc %0d got %b %h %b want %b %h %b", c,
                 bus1.anodes, bus1.segments, bus1.frame, m1_an, m1_seg, m1_frame);
      end
      if ($urandom_range(0, 15) == 0) bus8.value = $urandom;
      if ($urandom_range(0, 7) == 0)  bus1.value = $urandom;
      bus8.en = ($urandom_range(0, 7) != 0);
      bus1.en = ($urandom_range(0, 5) != 0);
      rst     = ($urandom_range(0, 149) == 0);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_no_tearing();
    test_enable();
    test_blanking();
    test_digits1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
